// File: rtl/ysyx_23060072_wbu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_wbu_pkg
//   Shared definitions for the writeback unit:
//     - default datapath / register-address widths
//     - load-type encodings (RISC-V funct3 of the load instruction)
//     - writeback FSM state encoding
// ---------------------------------------------------------------------------
package ysyx_23060072_wbu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;

   // Load types, funct3 encoding. Values 3, 6 and 7 are not loads and
   // fall through to a raw-word write.
   localparam logic [2:0] LD_LB  = 3'd0;
   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LW  = 3'd2;
   localparam logic [2:0] LD_LBU = 3'd4;
   localparam logic [2:0] LD_LHU = 3'd5;

   typedef enum logic [1:0] {
      WBU_IDLE     = 2'd0,
      WBU_WAIT_MEM = 2'd1,
      WBU_WRITE    = 2'd2
   } wbu_state_e;

endpackage : ysyx_23060072_wbu_pkg

// File: rtl/ysyx_23060072_ld_ext.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_ld_ext
//   Purely combinational load-data aligner / extender.
//   Ports:
//     ld_type_i [2:0]   funct3 of the load (LB/LH/LW/LBU/LHU)
//     addr_lo_i [1:0]   byte offset of the load address inside the word
//     rdata_i   [W-1:0] raw aligned word returned by memory
//     data_o    [W-1:0] value to write into the register file
//   Bytes are picked by addr_lo, halfwords by addr_lo[1] only (addr_lo[0]
//   is assumed zero for halfwords). LW and unknown types pass the word.
// ---------------------------------------------------------------------------
module ysyx_23060072_ld_ext
   import ysyx_23060072_wbu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        ld_type_i,
   input  logic [1:0]        addr_lo_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase

      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      data_o = rdata_i;
      case (ld_type_i)
         LD_LB:   data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_LH:   data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_LW:   data_o = rdata_i;
         LD_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule : ysyx_23060072_ld_ext

// File: rtl/ysyx_23060072_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_wbu
//   Writeback stage between execute/LSU and the register file.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     ex_*                retiring instruction from execute (valid/ready)
//     mem_rvalid_i/rdata  one-cycle load response from memory
//     wb_reg_addr_o       register file write address      (registered)
//     wb_flag_o           register file write enable pulse (registered)
//     wb_wdata_o          register file write data         (registered)
//     wb_commit_o         instruction retired pulse        (registered)
//     wb_busy_o           a load is outstanding            (registered)
//     dbg_state_o         current FSM state, for observation only
//
//   Handshake: a transfer happens on a rising edge where ex_valid_i and
//   ex_ready_o are both high. ex_ready_o depends on the state register only
//   (high in IDLE and WRITE), never on ex_valid_i, so execute may hold
//   valid and stream one instruction per cycle while we sit in WRITE.
// ---------------------------------------------------------------------------
module ysyx_23060072_wbu
   import ysyx_23060072_wbu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_rd_we_i,
   input  logic [DATA_W-1:0] ex_alu_res_i,
   input  logic              ex_is_load_i,
   input  logic [2:0]        ex_ld_type_i,
   input  logic [1:0]        ex_addr_lo_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [REG_AW-1:0] wb_reg_addr_o,
   output logic              wb_flag_o,
   output logic [DATA_W-1:0] wb_wdata_o,
   output logic              wb_commit_o,
   output logic              wb_busy_o,
   output logic [1:0]        dbg_state_o
);

   wbu_state_e        state_q,     state_d;
   logic [REG_AW-1:0] ld_rd_q,     ld_rd_d;
   logic              ld_we_q,     ld_we_d;
   logic [2:0]        ld_type_q,   ld_type_d;
   logic [1:0]        ld_lo_q,     ld_lo_d;
   logic [REG_AW-1:0] reg_addr_q,  reg_addr_d;
   logic              flag_q,      flag_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              commit_q,    commit_d;
   logic              busy_q,      busy_d;

   logic              accept;
   logic [DATA_W-1:0] ext_data;

   // Extraction uses the latched load attributes, not the live ex_* inputs,
   // since execute has moved on by the time the response arrives.
   ysyx_23060072_ld_ext #(
      .DATA_W (DATA_W)
   ) u_ld_ext (
      .ld_type_i (ld_type_q),
      .addr_lo_i (ld_lo_q),
      .rdata_i   (mem_rdata_i),
      .data_o    (ext_data)
   );

   assign ex_ready_o  = (state_q == WBU_IDLE) || (state_q == WBU_WRITE);
   assign accept      = ex_valid_i && ex_ready_o;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d    = state_q;
      ld_rd_d    = ld_rd_q;
      ld_we_d    = ld_we_q;
      ld_type_d  = ld_type_q;
      ld_lo_d    = ld_lo_q;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      flag_d     = 1'b0;
      commit_d   = 1'b0;

      case (state_q)
         WBU_IDLE, WBU_WRITE: begin
            state_d = WBU_IDLE;
            if (accept) begin
               if (ex_is_load_i) begin
                  // A response in this same cycle belongs to nothing we
                  // own yet, so it is deliberately not looked at here.
                  state_d   = WBU_WAIT_MEM;
                  ld_rd_d   = ex_rd_i;
                  ld_we_d   = ex_rd_we_i;
                  ld_type_d = ex_ld_type_i;
                  ld_lo_d   = ex_addr_lo_i;
               end else begin
                  state_d    = WBU_WRITE;
                  commit_d   = 1'b1;
                  flag_d     = ex_rd_we_i && (ex_rd_i != '0);
                  reg_addr_d = ex_rd_i;
                  wdata_d    = ex_alu_res_i;
               end
            end
         end
         WBU_WAIT_MEM: begin
            if (mem_rvalid_i) begin
               state_d    = WBU_WRITE;
               commit_d   = 1'b1;
               flag_d     = ld_we_q && (ld_rd_q != '0);
               reg_addr_d = ld_rd_q;
               wdata_d    = ext_data;
            end
         end
         default: state_d = WBU_IDLE;
      endcase

      busy_d = (state_d == WBU_WAIT_MEM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= WBU_IDLE;
         ld_rd_q    <= '0;
         ld_we_q    <= 1'b0;
         ld_type_q  <= 3'd0;
         ld_lo_q    <= 2'd0;
         reg_addr_q <= '0;
         flag_q     <= 1'b0;
         wdata_q    <= '0;
         commit_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_rd_q    <= ld_rd_d;
         ld_we_q    <= ld_we_d;
         ld_type_q  <= ld_type_d;
         ld_lo_q    <= ld_lo_d;
         reg_addr_q <= reg_addr_d;
         flag_q     <= flag_d;
         wdata_q    <= wdata_d;
         commit_q   <= commit_d;
         busy_q     <= busy_d;
      end
   end

   assign wb_reg_addr_o = reg_addr_q;
   assign wb_flag_o     = flag_q;
   assign wb_wdata_o    = wdata_q;
   assign wb_commit_o   = commit_q;
   assign wb_busy_o     = busy_q;

endmodule : ysyx_23060072_wbu
